reg_file_dumper: RTL
====================

# reg_file_dumper

Sequential read-side scanner for the CPU register file. On a start pulse it walks the register file's asynchronous read port over an inclusive, optionally wrapping address range. For each register it captures the word and offers it, tagged with its address, over a valid/ready stream. The stream feeds the debug/display path, such as a 7-segment or UART trace, and the block never writes the register file.

## Interface
- depth, 4, address width; the register file holds 2^depth entries
- width, 32, data word width
- clk  in  1  system clock, all state updates on rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  synchronous cancel of an in-progress scan
- first_addr  in  depth  first register of the scan, sampled with start
- last_addr  in  depth  last register of the scan (inclusive), sampled with start
- r_addr  out  depth  drives the register file read address
- r_data  in  width  register file read data, combinational from r_addr
- out_data  out  width  captured register contents
- out_addr  out  depth  address the out_data word came from
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  downstream accepts the word
- busy  out  1  scan in progress (any state except IDLE)
- done  out  1  one-cycle pulse when a scan completes normally

## Operation
- State machine: IDLE, FETCH, SEND, DONE. Registers: cur_addr, end_addr, out_data, out_addr.
- IDLE
  - busy=0, out_valid=0.
  - If start=1: cur_addr←first_addr, end_addr←last_addr, go to FETCH.
- FETCH
  - r_addr=cur_addr.
  - On the edge: out_data←r_data, out_addr←cur_addr, go to SEND.
- SEND
  - out_valid=1. out_data and out_addr are held stable until the handshake.
  - When out_valid&&out_ready:
    - If cur_addr==end_addr, go to DONE.
    - Otherwise cur_addr←cur_addr+1 modulo 2^depth, go to FETCH.
- DONE
  - done=1 for exactly one cycle, then go to IDLE.
- r_addr equals cur_addr in every state, so it holds the last used address in IDLE. Reset value of r_addr is 0.
- Wrap-around
  - If last_addr<first_addr, the scan runs first_addr..2^depth-1, then 0..last_addr.
  - If first_addr==last_addr, exactly one word is sent.
  - A full dump is first=0, last=2^depth-1 (16 words at default).
- start while busy is ignored. start in the DONE cycle is also ignored.
- abort
  - In FETCH or SEND: go to IDLE on the next edge, out_valid drops, done is not pulsed, and the word is not counted as transferred.
  - abort takes priority over a same-cycle handshake.
  - In IDLE or DONE, abort has no effect.
- Write coincident with capture: if the register file writes address cur_addr on the same edge that FETCH captures, the pre-write contents are captured. A later scan shows the new value.

## Timing
- Reset (clr_n=0, asynchronous)
  - State=IDLE.
  - cur_addr, end_addr, out_addr, r_addr=0.
  - out_data=0.
  - out_valid, busy, done=0.
  - Reset mid-scan discards the scan immediately, with no done pulse.
- Latency:
  - start sampled at edge N → busy=1 and FETCH during cycle N+1.
  - out_valid=1 from edge N+2.
- Throughput: 2 cycles per word minimum (FETCH+SEND) with out_ready held high. A k-word scan with out_ready=1 takes 2k cycles from the FETCH entry to DONE, plus 1 DONE cycle.
- Backpressure: SEND persists indefinitely while out_ready=0. out_data and out_addr must not change during the stall.
- done is asserted in the cycle after the final handshake. busy=1 during DONE and drops to 0 the cycle after.

## Test plan
- Preload reg[i]=0x1000_0000+i. Scan first=0, last=15 with out_ready=1 → 16 words, out_addr 0..15, data 0x1000_0000..0x1000_000F. Exactly one done pulse, 33 cycles from FETCH entry to IDLE.
- Wrapping scan first=14, last=1 → out_addr sequence 14,15,0,1 with matching data, then done.
- Single-word scan first=last=7 with out_ready held low 5 cycles → out_valid stays high, out_data/out_addr (7) are stable throughout, and one transfer occurs when ready rises.
- Write reg[3]=0xDEAD_BEEF on the same edge FETCH captures address 3 → the old value is sent. A rescan of 3..3 sends 0xDEAD_BEEF.
- Abort during SEND of address 5 with out_ready=1 the same cycle → no transfer counted, out_valid=0 next cycle, no done, busy=0. A following start works normally.
- Drop clr_n mid-scan (address 9) → all outputs 0 immediately. start during busy is ignored (cur_addr unchanged).

Source files
------------

// File: rtl/reg_file_dumper.sv
// Register-file dump engine: walks an inclusive, optionally wrapping address
// range on the asynchronous read port and streams {address, word} pairs out.
module reg_file_dumper #(
    parameter int depth = 4,
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             abort,
    input  logic [depth-1:0] first_addr,
    input  logic [depth-1:0] last_addr,
    output logic [depth-1:0] r_addr,
    input  logic [width-1:0] r_data,
    output logic [width-1:0] out_data,
    output logic [depth-1:0] out_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [depth-1:0] addr_zero = {depth{1'b0}};
    localparam logic [depth-1:0] addr_one  = {{(depth-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] data_zero = {width{1'b0}};

    state_t             state_r, state_s;
    logic [depth-1:0]   cur_addr_r, cur_addr_s;
    logic [depth-1:0]   end_addr_r, end_addr_s;
    logic [width-1:0]   out_data_r, out_data_s;
    logic [depth-1:0]   out_addr_r, out_addr_s;
    logic               out_valid_r, out_valid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Next-state, datapath and output-flag decode; flags follow the next state
    // so that every output comes straight from a flop.
    always_comb begin
        state_s    = state_r;
        cur_addr_s = cur_addr_r;
        end_addr_s = end_addr_r;
        out_data_s = out_data_r;
        out_addr_s = out_addr_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_s = first_addr;
                    end_addr_s = last_addr;
                    state_s    = ST_FETCH;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_s    = ST_IDLE;
                end else begin
                    out_data_s = r_data;
                    out_addr_s = cur_addr_r;
                    state_s    = ST_SEND;
                end
            end
            ST_SEND: begin
                // abort wins over a handshake in the same cycle
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (out_ready) begin
                    if (cur_addr_r == end_addr_r) begin
                        state_s    = ST_DONE;
                    end else begin
                        cur_addr_s = cur_addr_r + addr_one;
                        state_s    = ST_FETCH;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s      = (state_s != ST_IDLE);
        out_valid_s = (state_s == ST_SEND);
        done_s      = (state_s == ST_DONE);
    end

    // State, address, captured word and output flag registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= addr_zero;
            end_addr_r  <= addr_zero;
            out_data_r  <= data_zero;
            out_addr_r  <= addr_zero;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_addr_r  <= cur_addr_s;
            end_addr_r  <= end_addr_s;
            out_data_r  <= out_data_s;
            out_addr_r  <= out_addr_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign r_addr    = cur_addr_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
